// File: rtl/cmpm_sar_scan.sv
// Round-robin SAR scan controller for the shared comparator/mux ADC front end.
// Define CMPM_SYNC_EN to pass comp_o through a 2-flop synchronizer with longer bit waits.
module cmpm_sar_scan #(
  parameter int unsigned N_CHNL = 14,
  parameter int unsigned CW     = $clog2(N_CHNL),
  parameter logic [7:0]  T_RST  = 8'd2,
  parameter logic [7:0]  T_GAP  = 8'd1,
  parameter logic [7:0]  T_SMP  = 8'd4,
  parameter logic [7:0]  T_BIT  = 8'd2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scan_en,
  input  logic [N_CHNL-1:0]      chnl_en,
  input  logic                   comp_o,
  output logic [N_CHNL-1:0]      dac_sel,
  output logic                   sh_rst,
  output logic                   sh_hold,
  output logic [9:0]             dac_code,
  output logic                   adc_vld,
  output logic [CW-1:0]          adc_chnl,
  output logic [9:0]             adc_data,
  output logic [N_CHNL*10-1:0]   adc_res,
  output logic                   busy
);

  localparam logic [7:0] TRstE = (T_RST == 8'd0) ? 8'd1 : T_RST;
  localparam logic [7:0] TGapE = (T_GAP == 8'd0) ? 8'd1 : T_GAP;
  localparam logic [7:0] TSmpE = (T_SMP == 8'd0) ? 8'd1 : T_SMP;
  localparam logic [7:0] TBitE = (T_BIT == 8'd0) ? 8'd1 : T_BIT;

  typedef enum logic [2:0] {StIdle, StRst, StGap1, StSmp, StHld, StBit, StDone} state_e;

  logic                 w_comp;
  logic [CW-1:0]        w_next_ch;
  logic [9:0]           w_acc_nxt;
  logic [9:0]           w_trial_nxt;

  state_e               r_state;
  logic [8:0]           r_cnt;
  logic [3:0]           r_bit;
  logic [9:0]           r_acc;
  logic [CW-1:0]        r_chnl;
  logic [CW-1:0]        r_last;
  logic [N_CHNL-1:0]    r_dac_sel;
  logic                 r_sh_rst;
  logic                 r_sh_hold;
  logic [9:0]           r_dac_code;
  logic                 r_vld;
  logic [CW-1:0]        r_adc_chnl;
  logic [9:0]           r_adc_data;
  logic [N_CHNL*10-1:0] r_adc_res;
  logic                 r_busy;

`ifdef CMPM_SYNC_EN
  localparam logic [8:0] TBitW = {1'b0, TBitE} + 9'd2;
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], comp_o};
  end

  assign w_comp = r_sync[1];
`else
  localparam logic [8:0] TBitW = {1'b0, TBitE};

  assign w_comp = comp_o;
`endif

  // Smallest forward distance from r_last wins, hence the descending scan.
  always_comb begin
    w_next_ch = r_last;
    for (int k = int'(N_CHNL); k >= 1; k--) begin
      if (chnl_en[CW'((int'(r_last) + k) % int'(N_CHNL))]) begin
        w_next_ch = CW'((int'(r_last) + k) % int'(N_CHNL));
      end
    end
  end

  always_comb begin
    w_acc_nxt        = r_acc;
    w_acc_nxt[r_bit] = w_comp;
    w_trial_nxt      = w_acc_nxt | (10'd1 << (r_bit - 4'd1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_acc      <= '0;
      r_chnl     <= '0;
      r_last     <= CW'(N_CHNL - 1);
      r_dac_sel  <= '0;
      r_sh_rst   <= 1'b0;
      r_sh_hold  <= 1'b1;
      r_dac_code <= '0;
      r_vld      <= 1'b0;
      r_adc_chnl <= '0;
      r_adc_data <= '0;
      r_adc_res  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (scan_en && |chnl_en) begin
            r_chnl    <= w_next_ch;
            r_acc     <= '0;
            r_cnt     <= {1'b0, TRstE} - 9'd1;
            r_sh_rst  <= 1'b1;
            r_sh_hold <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= StRst;
          end
        end
        StRst: begin
          if (r_cnt == '0) begin
            r_sh_rst <= 1'b0;
            r_cnt    <= {1'b0, TGapE} - 9'd1;
            r_state  <= StGap1;
          end else begin
            r_cnt <= r_cnt - 9'd1;
          end
        end
        StGap1: begin
          if (r_cnt == '0) begin
            r_dac_sel <= N_CHNL'(1) << r_chnl;
            r_sh_hold <= 1'b0;
            r_cnt     <= {1'b0, TSmpE} - 9'd1;
            r_state   <= StSmp;
          end else begin
            r_cnt <= r_cnt - 9'd1;
          end
        end
        StSmp: begin
          if (r_cnt == '0) begin
            r_sh_hold <= 1'b1;
            r_cnt     <= {1'b0, TGapE} - 9'd1;
            r_state   <= StHld;
          end else begin
            r_cnt <= r_cnt - 9'd1;
          end
        end
        StHld: begin
          if (r_cnt == '0) begin
            r_dac_sel  <= '0;
            r_bit      <= 4'd9;
            r_dac_code <= 10'h200;
            r_cnt      <= TBitW - 9'd1;
            r_state    <= StBit;
          end else begin
            r_cnt <= r_cnt - 9'd1;
          end
        end
        StBit: begin
          if (r_cnt == '0) begin
            r_acc <= w_acc_nxt;
            if (r_bit == 4'd0) begin
              r_dac_code <= '0;
              r_vld      <= 1'b1;
              r_adc_chnl <= r_chnl;
              r_adc_data <= w_acc_nxt;
              r_last     <= r_chnl;
              for (int i = 0; i < int'(N_CHNL); i++) begin
                if (r_chnl == CW'(i)) r_adc_res[i*10 +: 10] <= w_acc_nxt;
              end
              r_state <= StDone;
            end else begin
              r_bit      <= r_bit - 4'd1;
              r_dac_code <= w_trial_nxt;
              r_cnt      <= TBitW - 9'd1;
            end
          end else begin
            r_cnt <= r_cnt - 9'd1;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dac_sel  = r_dac_sel;
  assign sh_rst   = r_sh_rst;
  assign sh_hold  = r_sh_hold;
  assign dac_code = r_dac_code;
  assign adc_vld  = r_vld;
  assign adc_chnl = r_adc_chnl;
  assign adc_data = r_adc_data;
  assign adc_res  = r_adc_res;
  assign busy     = r_busy;

endmodule

// File: tb/tb_cmpm_sar_scan.sv
// Directed bench for cmpm_sar_scan with a sample-and-hold / comparator model (2 mV per LSB).
module tb_cmpm_sar_scan;

`ifdef CMPM_SYNC_EN
  localparam int BitW   = 4;
  localparam int Period = 50;
`else
  localparam int BitW   = 2;
  localparam int Period = 30;
`endif

  logic          clk;
  logic          rst;
  logic          scan_en;
  logic [13:0]   chnl_en;
  logic          comp_o;
  logic [13:0]   dac_sel;
  logic          sh_rst;
  logic          sh_hold;
  logic [9:0]    dac_code;
  logic          adc_vld;
  logic [3:0]    adc_chnl;
  logic [9:0]    adc_data;
  logic [139:0]  adc_res;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int vld_cnt = 0;
  int mv [14];
  int cap_mv = 0;

  logic [13:0] p_sel;
  logic        p_rst;
  logic        p_hold;

  cmpm_sar_scan dut (
    .clk      (clk),
    .rst      (rst),
    .scan_en  (scan_en),
    .chnl_en  (chnl_en),
    .comp_o   (comp_o),
    .dac_sel  (dac_sel),
    .sh_rst   (sh_rst),
    .sh_hold  (sh_hold),
    .dac_code (dac_code),
    .adc_vld  (adc_vld),
    .adc_chnl (adc_chnl),
    .adc_data (adc_data),
    .adc_res  (adc_res),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #40 clk = ~clk;

  // Track-and-hold: the cap follows the selected channel while hold is low.
  always @(posedge clk) begin
    if (!sh_hold) begin
      for (int i = 0; i < 14; i++) if (dac_sel[i]) cap_mv <= mv[i];
    end
  end

  assign comp_o = (cap_mv >= 2 * int'(dac_code));

  always @(negedge clk) begin
    if (!rst) begin
      if (sh_rst && dac_sel != 14'd0) viol++;
      if (dac_sel != p_sel && sh_rst != p_rst) viol++;
      if (p_hold && !sh_hold && (sh_rst || p_rst)) viol++;
      if (!$onehot0(dac_sel)) viol++;
      if (adc_vld) vld_cnt++;
    end
    p_sel  = dac_sel;
    p_rst  = sh_rst;
    p_hold = sh_hold;
  end

  task automatic chk(input string tag, input logic [139:0] got, input logic [139:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_vld(output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      n++;
      if (adc_vld) found = 1'b1;
    end
    chk("vld_wait", 140'(found), 140'(1));
  endtask

  task automatic wait_code_nz();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dac_code != 10'd0) found = 1'b1;
    end
    chk("code_wait", 140'(found), 140'(1));
  endtask

  task automatic wait_sel_nz();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dac_sel != 14'd0) found = 1'b1;
    end
    chk("sel_wait", 140'(found), 140'(1));
  endtask

  initial begin
    int          n;
    int          vld_snap;
    logic [9:0]  trial;
    logic [139:0] exp_res;
    int          exp_ch [4];
    int          exp_dat [4];

    for (int i = 0; i < 14; i++) mv[i] = 0;
    mv[0]  = 100;
    mv[2]  = 1000;
    mv[13] = 1500;
    rst     = 1'b1;
    scan_en = 1'b0;
    chnl_en = 14'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_dac_sel", 140'(dac_sel), 140'(0));
    chk("rst_sh_rst", 140'(sh_rst), 140'(0));
    chk("rst_sh_hold", 140'(sh_hold), 140'(1));
    chk("rst_dac_code", 140'(dac_code), 140'(0));
    chk("rst_vld", 140'(adc_vld), 140'(0));
    chk("rst_chnl", 140'(adc_chnl), 140'(0));
    chk("rst_data", 140'(adc_data), 140'(0));
    chk("rst_res", adc_res, 140'(0));
    chk("rst_busy", 140'(busy), 140'(0));

    // Single channel, 1000 mV -> 500, back-to-back conversions.
    chnl_en = 14'h0004;
    scan_en = 1'b1;
    wait_vld(n);
    chk("c2_chnl", 140'(adc_chnl), 140'(2));
    chk("c2_data", 140'(adc_data), 140'(500));
    chk("c2_res", 140'(adc_res[20 +: 10]), 140'(500));
    chk("c2_busy", 140'(busy), 140'(1));
    wait_vld(n);
    chk("period", 140'(n), 140'(Period));
    chk("c2_data2", 140'(adc_data), 140'(500));

    // 0 mV: every trial rejected, codes walk 0x200 down to 0x001.
    mv[2] = 0;
    wait_code_nz();
    for (int k = 0; k < 10; k++) begin
      trial = 10'h200 >> k;
      chk("dac_seq", 140'(dac_code), 140'(trial));
      if (k < 9) repeat (BitW) @(negedge clk);
    end
    wait_vld(n);
    chk("zero_data", 140'(adc_data), 140'(0));
    chk("zero_res", 140'(adc_res[20 +: 10]), 140'(0));
    chk("zero_code_after", 140'(dac_code), 140'(0));

    // Full scale.
    mv[2] = 2046;
    wait_vld(n);
    chk("fs_data", 140'(adc_data), 140'(10'h3FF));
    chk("fs_res", 140'(adc_res[20 +: 10]), 140'(10'h3FF));

    // scan_en dropped during sampling: one more result, then idle.
    mv[2] = 1000;
    wait_sel_nz();
    scan_en  = 1'b0;
    vld_snap = vld_cnt;
    wait_vld(n);
    chk("drop_chnl", 140'(adc_chnl), 140'(2));
    chk("drop_data", 140'(adc_data), 140'(500));
    repeat (40) @(negedge clk);
    chk("drop_busy", 140'(busy), 140'(0));
    chk("drop_vld_cnt", 140'(vld_cnt), 140'(vld_snap + 1));

    // Reset pulsed during the bit phase.
    chnl_en = 14'h2005;
    scan_en = 1'b1;
    wait_code_nz();
    rst = 1'b1;
    #1;
    chk("arst_dac_code", 140'(dac_code), 140'(0));
    chk("arst_sh_hold", 140'(sh_hold), 140'(1));
    chk("arst_res", adc_res, 140'(0));
    chk("arst_busy", 140'(busy), 140'(0));
    @(negedge clk);
    rst = 1'b0;

    exp_ch  = '{0, 2, 13, 0};
    exp_dat = '{50, 500, 750, 50};
    for (int j = 0; j < 4; j++) begin
      wait_vld(n);
      chk("rr_chnl", 140'(adc_chnl), 140'(exp_ch[j]));
      chk("rr_data", 140'(adc_data), 140'(exp_dat[j]));
    end
    exp_res = '0;
    exp_res[0 +: 10]   = 10'd50;
    exp_res[20 +: 10]  = 10'd500;
    exp_res[130 +: 10] = 10'd750;
    chk("rr_res", adc_res, exp_res);

    chk("invariants", 140'(viol), 140'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
